tri_plane_clipper: RTL and testbench

- Sutherland-Hodgman clipper for one triangle against one homogeneous plane, all values 12.12 fixed point.
- Classifies each vertex by the sign of its plane dot product, then walks the three edges in order.
- For every edge that crosses the plane, it issues a start/done request to the external segment–plane intersection unit. It is the initiator of that interface.
- Streams the resulting 0, 3 or 4 polygon vertices downstream over a valid/ready handshake. Sits in preprocessing between vertex transform and triangle setup.

---
 rtl/clip_pkg.sv | 36 +++
 rtl/tri_plane_clipper_dot4.sv | 24 ++
 rtl/tri_plane_clipper.sv | 254 +++++++++++++++++++++++++
 tb/tb_tri_plane_clipper.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clip_pkg.sv
// Shared definitions for the triangle/plane clipper.
//   CLIP_WIDTH : coordinate width (signed 12.12 fixed point)
//   Q12_ONE / Q12_FRAC : fixed-point helpers
//   vertex_t {w,z,y,x}, plane_t {d,c,b,a} : packed coordinate records, x/a in LSBs
//   state_t : clipper FSM states
package clip_pkg;

  localparam int unsigned CLIP_WIDTH = 24;
  localparam int          Q12_ONE    = 4096;
  localparam int          Q12_FRAC   = 12;

  typedef struct packed {
    logic signed [CLIP_WIDTH-1:0] w;
    logic signed [CLIP_WIDTH-1:0] z;
    logic signed [CLIP_WIDTH-1:0] y;
    logic signed [CLIP_WIDTH-1:0] x;
  } vertex_t;

  typedef struct packed {
    logic signed [CLIP_WIDTH-1:0] d;
    logic signed [CLIP_WIDTH-1:0] c;
    logic signed [CLIP_WIDTH-1:0] b;
    logic signed [CLIP_WIDTH-1:0] a;
  } plane_t;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    DECIDE,
    EDGE,
    ISECT,
    WAIT,
    EMIT
  } state_t;

endpackage

// File: rtl/tri_plane_clipper_dot4.sv
// plane_dot4: combinational 4-term multiply-accumulate.
//   vertex_i : packed {w,z,y,x}, WIDTH bits each, signed
//   plane_i  : packed {d,c,b,a}, WIDTH bits each, signed
//   dot_o    : a*x + b*y + c*z + d*w as a 64-bit signed value
module plane_dot4 #(
  parameter int unsigned WIDTH = 24
) (
  input  logic        [4*WIDTH-1:0] vertex_i,
  input  logic        [4*WIDTH-1:0] plane_i,
  output logic signed [63:0]        dot_o
);

  logic signed [2*WIDTH-1:0] prod;

  always_comb begin
    dot_o = '0;
    prod  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      prod  = $signed(vertex_i[i*WIDTH +: WIDTH]) * $signed(plane_i[i*WIDTH +: WIDTH]);
      dot_o = dot_o + 64'(prod);
    end
  end

endmodule

// File: rtl/tri_plane_clipper.sv
// tri_plane_clipper: Sutherland-Hodgman clip of one triangle against one
// homogeneous plane (12.12 fixed point).
//   tri_*       : triangle input handshake (ready only in IDLE), vertices, plane
//   isect_*     : initiator side of the segment/plane intersection unit
//   out_*       : clipped polygon stream (3 or 4 vertices), valid/ready
//   cull_o      : one-cycle pulse when the triangle is entirely outside
// Optional macro CLIP_STATS_EN adds stat_accept_o / stat_clip_o / stat_cull_o
// 32-bit saturating counters.
module tri_plane_clipper
  import clip_pkg::*;
#(
  parameter  int unsigned WIDTH = 24,
  localparam int unsigned VW    = 4*WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          tri_valid_i,
  output logic          tri_ready_o,
  input  logic [VW-1:0] tri_v0_i,
  input  logic [VW-1:0] tri_v1_i,
  input  logic [VW-1:0] tri_v2_i,
  input  logic [VW-1:0] plane_i,
  output logic          isect_start_o,
  output logic [VW-1:0] isect_v1_o,
  output logic [VW-1:0] isect_v2_o,
  output logic [VW-1:0] isect_plane_o,
  input  logic [VW-1:0] isect_result_i,
  input  logic          isect_done_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [VW-1:0] out_vertex_o,
  output logic          out_last_o,
  output logic [2:0]    out_count_o,
  output logic          cull_o
`ifdef CLIP_STATS_EN
  ,
  output logic [31:0]   stat_accept_o,
  output logic [31:0]   stat_clip_o,
  output logic [31:0]   stat_cull_o
`endif
);

  state_t             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [1:0]         edge_q, edge_d;
  logic [2:0]         inside_q, inside_d;
  logic [2:0]         count_q, count_d;
  logic [2:0]         idx_q, idx_d;
  logic               pend_q, pend_d;
  logic               cull_q, cull_d;
  logic [VW-1:0]      v_q [3];
  logic [VW-1:0]      v_d [3];
  logic [VW-1:0]      plane_q, plane_d;
  logic [VW-1:0]      outv_q, outv_d;

  logic [1:0]         nxt_e;
  logic [1:0]         k;
  logic [VW-1:0]      cls_v, s_v, n_v;
  logic               s_in, n_in, last;
  logic signed [63:0] dot;

  plane_dot4 #(.WIDTH(WIDTH)) u_dot (
    .vertex_i (cls_v),
    .plane_i  (plane_q),
    .dot_o    (dot)
  );

  assign nxt_e = (edge_q == 2'd2) ? 2'd0 : edge_q + 2'd1;
  assign k     = 2'(inside_q[0]) + 2'(inside_q[1]) + 2'(inside_q[2]);
  assign last  = (idx_q == count_q - 3'd1);

  // Constant-index muxes keep every array select in range.
  always_comb begin
    cls_v = v_q[0];
    s_v   = v_q[0];
    n_v   = v_q[1];
    s_in  = inside_q[0];
    n_in  = inside_q[1];
    case (cnt_q)
      2'd1:    cls_v = v_q[1];
      2'd2:    cls_v = v_q[2];
      default: cls_v = v_q[0];
    endcase
    case (edge_q)
      2'd1: begin s_v = v_q[1]; s_in = inside_q[1]; end
      2'd2: begin s_v = v_q[2]; s_in = inside_q[2]; end
      default: ;
    endcase
    case (nxt_e)
      2'd0: begin n_v = v_q[0]; n_in = inside_q[0]; end
      2'd2: begin n_v = v_q[2]; n_in = inside_q[2]; end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    inside_d = inside_q;
    count_d  = count_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    cull_d   = 1'b0;
    v_d      = v_q;
    plane_d  = plane_q;
    outv_d   = outv_q;
    case (state_q)
      IDLE: begin
        if (tri_valid_i) begin
          v_d[0]  = tri_v0_i;
          v_d[1]  = tri_v1_i;
          v_d[2]  = tri_v2_i;
          plane_d = plane_i;
          cnt_d   = 2'd0;
          state_d = CLASSIFY;
        end
      end
      CLASSIFY: begin
        case (cnt_q)
          2'd0:    inside_d[0] = (dot >= 64'sd0);
          2'd1:    inside_d[1] = (dot >= 64'sd0);
          default: inside_d[2] = (dot >= 64'sd0);
        endcase
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) state_d = DECIDE;
      end
      DECIDE: begin
        if (k == 2'd0) begin
          cull_d  = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = (k == 2'd2) ? 3'd4 : 3'd3;
          edge_d  = 2'd0;
          idx_d   = 3'd0;
          pend_d  = 1'b0;
          state_d = EDGE;
        end
      end
      EDGE: begin
        if (s_in && n_in) begin
          outv_d  = n_v;
          state_d = EMIT;
        end else if (s_in || n_in) begin
          // Entering edge (out->in) emits the crossing, then the end vertex.
          pend_d  = n_in;
          state_d = ISECT;
        end else if (edge_q == 2'd2) begin
          state_d = IDLE;
        end else begin
          edge_d = nxt_e;
        end
      end
      ISECT: state_d = WAIT;
      WAIT: begin
        if (isect_done_i) begin
          outv_d  = isect_result_i;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready_i) begin
          idx_d = idx_q + 3'd1;
          if (last) begin
            state_d = IDLE;
          end else if (pend_q) begin
            outv_d = n_v;
            pend_d = 1'b0;
          end else begin
            edge_d  = nxt_e;
            state_d = EDGE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      edge_q   <= '0;
      inside_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      pend_q   <= 1'b0;
      cull_q   <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) v_q[i] <= '0;
      plane_q  <= '0;
      outv_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      inside_q <= inside_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      cull_q   <= cull_d;
      v_q      <= v_d;
      plane_q  <= plane_d;
      outv_q   <= outv_d;
    end
  end

  assign tri_ready_o   = (state_q == IDLE);
  assign isect_start_o = (state_q == ISECT);
  assign isect_v1_o    = s_v;
  assign isect_v2_o    = n_v;
  assign isect_plane_o = plane_q;
  assign out_valid_o   = (state_q == EMIT);
  assign out_vertex_o  = outv_q;
  assign out_last_o    = out_valid_o && last;
  assign out_count_o   = count_q;
  assign cull_o        = cull_q;

`ifdef CLIP_STATS_EN
  logic [31:0] st_acc_q, st_acc_d;
  logic [31:0] st_clip_q, st_clip_d;
  logic [31:0] st_cull_q, st_cull_d;

  always_comb begin
    st_acc_d  = st_acc_q;
    st_clip_d = st_clip_q;
    st_cull_d = st_cull_q;
    if (state_q == IDLE && tri_valid_i && st_acc_q != '1) st_acc_d = st_acc_q + 32'd1;
    if (state_q == DECIDE) begin
      if (k == 2'd0) begin
        if (st_cull_q != '1) st_cull_d = st_cull_q + 32'd1;
      end else if (k != 2'd3) begin
        if (st_clip_q != '1) st_clip_d = st_clip_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_acc_q  <= '0;
      st_clip_q <= '0;
      st_cull_q <= '0;
    end else begin
      st_acc_q  <= st_acc_d;
      st_clip_q <= st_clip_d;
      st_cull_q <= st_cull_d;
    end
  end

  assign stat_accept_o = st_acc_q;
  assign stat_clip_o   = st_clip_q;
  assign stat_cull_o   = st_cull_q;
`endif

endmodule

// File: tb/tb_tri_plane_clipper.sv
// Directed, table-driven bench for tri_plane_clipper with a one-cycle-latency
// intersection responder model.
module tb_tri_plane_clipper;
  import clip_pkg::*;

  localparam int unsigned W  = 24;
  localparam int unsigned VW = 4*W;
  localparam logic [W-1:0] ONE  = 24'h001000;
  localparam logic [W-1:0] ZERO = 24'h000000;
  localparam logic [W-1:0] M1   = 24'hFFF000;
  localparam logic [W-1:0] M2   = 24'hFFE000;
  localparam logic [W-1:0] M3   = 24'hFFD000;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          tri_valid_i;
  logic          tri_ready_o;
  logic [VW-1:0] tri_v0_i, tri_v1_i, tri_v2_i, plane_i;
  logic          isect_start_o;
  logic [VW-1:0] isect_v1_o, isect_v2_o, isect_plane_o;
  logic [VW-1:0] isect_result_i;
  logic          isect_done_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [VW-1:0] out_vertex_o;
  logic          out_last_o;
  logic [2:0]    out_count_o;
  logic          cull_o;
`ifdef CLIP_STATS_EN
  logic [31:0]   stat_accept_o, stat_clip_o, stat_cull_o;
`endif

  tri_plane_clipper #(.WIDTH(W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .tri_valid_i    (tri_valid_i),
    .tri_ready_o    (tri_ready_o),
    .tri_v0_i       (tri_v0_i),
    .tri_v1_i       (tri_v1_i),
    .tri_v2_i       (tri_v2_i),
    .plane_i        (plane_i),
    .isect_start_o  (isect_start_o),
    .isect_v1_o     (isect_v1_o),
    .isect_v2_o     (isect_v2_o),
    .isect_plane_o  (isect_plane_o),
    .isect_result_i (isect_result_i),
    .isect_done_i   (isect_done_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_vertex_o   (out_vertex_o),
    .out_last_o     (out_last_o),
    .out_count_o    (out_count_o),
    .cull_o         (cull_o)
`ifdef CLIP_STATS_EN
    ,
    .stat_accept_o  (stat_accept_o),
    .stat_clip_o    (stat_clip_o),
    .stat_cull_o    (stat_cull_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int req_count = 0;
  int req_base = 0;
  int inject_cnt = 0;
  logic resp_en = 1'b1;
  logic [1:0][VW-1:0] exp_rq1, exp_rq2;
  localparam logic [VW-1:0] PLANE = {ONE, ONE, ZERO, ZERO};

  typedef struct packed {
    logic [VW-1:0]      v0, v1, v2;
    int                 n_out;
    logic [2:0]         cnt;
    logic [3:0][VW-1:0] ev;
    int                 n_req;
    logic [1:0][VW-1:0] rq1, rq2;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [VW-1:0] vtx(input logic [W-1:0] w, z, y, x);
    vertex_t v;
    v.w = w; v.z = z; v.y = y; v.x = x;
    return v;
  endfunction

  // Responder model result: on the plane (z=-1.0, w=1.0), x tags the endpoints.
  function automatic logic [VW-1:0] isect_model(input logic [VW-1:0] s, n);
    return vtx(ONE, M1, ZERO, s[W-1:0] + n[W-1:0]);
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %b required %b", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Intersection unit model: done one cycle after the start pulse.
  initial begin : responder
    int inject_seen;
    logic resp_pend;
    logic [VW-1:0] pend_s, pend_n;
    inject_seen = 0;
    resp_pend = 1'b0;
    pend_s = '0;
    pend_n = '0;
    isect_done_i = 1'b0;
    isect_result_i = '0;
    forever begin
      @(posedge clk_i); #1;
      isect_done_i = 1'b0;
      if (inject_seen != inject_cnt) begin
        inject_seen = inject_cnt;
        isect_done_i = 1'b1;
        isect_result_i = '1;
      end else if (resp_pend) begin
        resp_pend = 1'b0;
        isect_done_i = 1'b1;
        isect_result_i = isect_model(pend_s, pend_n);
      end
      if (isect_start_o) begin
        if (req_count - req_base >= 0 && req_count - req_base < 2) begin
          chk("isect_v1", isect_v1_o, exp_rq1[req_count - req_base]);
          chk("isect_v2", isect_v2_o, exp_rq2[req_count - req_base]);
          chk("isect_plane", isect_plane_o, PLANE);
        end
        req_count++;
        if (resp_en) begin
          resp_pend = 1'b1;
          pend_s = isect_v1_o;
          pend_n = isect_v2_o;
        end
      end
    end
  end

  task automatic send(input logic [VW-1:0] a, b, c);
    int cyc = 0;
    while (!tri_ready_o && cyc < 100) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    chk1("ready_before_send", tri_ready_o, 1'b1);
    tri_v0_i = a; tri_v1_i = b; tri_v2_i = c; plane_i = PLANE;
    tri_valid_i = 1'b1;
    @(posedge clk_i); #1;
    tri_valid_i = 1'b0;
    chk1("ready_low_after_accept", tri_ready_o, 1'b0);
  endtask

  task automatic collect(input int n, input logic [3:0][VW-1:0] ev, input logic [2:0] ecnt, input int stall);
    int idx = 0;
    int cyc = 0;
    logic extra = 1'b0;
    logic stable;
    logic [VW-1:0] held;
    out_ready_i = (stall == 0);
    while (idx < n && cyc < 500) begin
      @(posedge clk_i); #1;
      cyc++;
      if (out_valid_o) begin
        chk("out_vertex", out_vertex_o, ev[idx]);
        chk1("out_last", out_last_o, idx == n - 1);
        chk("out_count", VW'(out_count_o), VW'(ecnt));
        chk1("tri_ready_busy", tri_ready_o, 1'b0);
        if (stall > 0) begin
          held = out_vertex_o;
          stable = 1'b1;
          for (int s = 0; s < stall; s++) begin
            @(posedge clk_i); #1;
            if (!out_valid_o || out_vertex_o !== held || tri_ready_o) stable = 1'b0;
          end
          chk1("stall_stable", stable, 1'b1);
          out_ready_i = 1'b1;
          @(posedge clk_i); #1;
          out_ready_i = 1'b0;
        end
        idx++;
      end
    end
    chki("collect_count", idx, n);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk_i); #1;
      if (out_valid_o) extra = 1'b1;
    end
    chk1("no_extra_vertex", extra, 1'b0);
    chk1("tri_ready_idle", tri_ready_o, 1'b1);
  endtask

  task automatic apply_vec(input int i, input int stall);
    vec_t t;
    int first = -1;
    int pulses = 0;
    logic vld = 1'b0;
    t = vecs[i];
    req_base = req_count;
    exp_rq1 = t.rq1;
    exp_rq2 = t.rq2;
    send(t.v0, t.v1, t.v2);
    if (t.n_out == 0) begin
      for (int j = 1; j <= 8; j++) begin
        @(posedge clk_i); #1;
        if (cull_o) begin
          pulses++;
          if (first < 0) first = j;
        end
        if (out_valid_o) vld = 1'b1;
      end
      chki("cull_time", first, 4);
      chki("cull_pulses", pulses, 1);
      chk1("cull_no_valid", vld, 1'b0);
    end else begin
      collect(t.n_out, t.ev, t.cnt, stall);
    end
    chki("isect_requests", req_count - req_base, t.n_req);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [VW-1:0] a, b, c;
    int cyc;
    rst_ni = 1'b0;
    tri_valid_i = 1'b0;
    tri_v0_i = '0; tri_v1_i = '0; tri_v2_i = '0; plane_i = '0;
    out_ready_i = 1'b0;
    exp_rq1 = '0; exp_rq2 = '0;

    // Case 1: all inside
    a = vtx(ONE, ZERO, 24'h000100, 24'h000011);
    b = vtx(ONE, ZERO, 24'h000200, 24'h000022);
    c = vtx(ONE, ZERO, 24'h000300, 24'h000033);
    vecs[0] = '0;
    vecs[0].v0 = a; vecs[0].v1 = b; vecs[0].v2 = c;
    vecs[0].n_out = 3; vecs[0].cnt = 3'd3;
    vecs[0].ev[0] = b; vecs[0].ev[1] = c; vecs[0].ev[2] = a;
    // Case 2: all outside
    vecs[1] = '0;
    vecs[1].v0 = vtx(ONE, M2, ZERO, 24'h000011);
    vecs[1].v1 = vtx(ONE, M2, ZERO, 24'h000022);
    vecs[1].v2 = vtx(ONE, M2, ZERO, 24'h000033);
    // Case 3: v0 outside -> quad
    vecs[2] = '0;
    vecs[2].v0 = vtx(ONE, M3, ZERO, 24'h000011);
    vecs[2].v1 = b; vecs[2].v2 = c;
    vecs[2].n_out = 4; vecs[2].cnt = 3'd4;
    vecs[2].ev[0] = isect_model(vecs[2].v0, b);
    vecs[2].ev[1] = b;
    vecs[2].ev[2] = c;
    vecs[2].ev[3] = isect_model(c, vecs[2].v0);
    vecs[2].n_req = 2;
    vecs[2].rq1[0] = vecs[2].v0; vecs[2].rq2[0] = b;
    vecs[2].rq1[1] = c;          vecs[2].rq2[1] = vecs[2].v0;
    // Case 4: v0 dot exactly zero counts as inside
    vecs[3] = '0;
    vecs[3].v0 = vtx(ONE, M1, ZERO, 24'h000011);
    vecs[3].v1 = b; vecs[3].v2 = c;
    vecs[3].n_out = 3; vecs[3].cnt = 3'd3;
    vecs[3].ev[0] = b; vecs[3].ev[1] = c; vecs[3].ev[2] = vecs[3].v0;
    // Case 5: only v0 inside -> triangle with two crossings
    vecs[4] = '0;
    vecs[4].v0 = a;
    vecs[4].v1 = vtx(ONE, M2, ZERO, 24'h000022);
    vecs[4].v2 = vtx(ONE, M2, ZERO, 24'h000033);
    vecs[4].n_out = 3; vecs[4].cnt = 3'd3;
    vecs[4].ev[0] = isect_model(a, vecs[4].v1);
    vecs[4].ev[1] = isect_model(vecs[4].v2, a);
    vecs[4].ev[2] = a;
    vecs[4].n_req = 2;
    vecs[4].rq1[0] = a;           vecs[4].rq2[0] = vecs[4].v1;
    vecs[4].rq1[1] = vecs[4].v2;  vecs[4].rq2[1] = a;

    repeat (3) @(posedge clk_i);
    #1;
    chk1("rst_tri_ready", tri_ready_o, 1'b1);
    chk1("rst_out_valid", out_valid_o, 1'b0);
    chk1("rst_isect_start", isect_start_o, 1'b0);
    chk1("rst_cull", cull_o, 1'b0);
    chk1("rst_out_last", out_last_o, 1'b0);
    chk("rst_out_count", VW'(out_count_o), '0);
    chk("rst_isect_plane", isect_plane_o, '0);
    chk("rst_out_vertex", out_vertex_o, '0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 5; i++) apply_vec(i, 0);

    // Back-pressure: 10 stall cycles on every vertex of the quad case
    apply_vec(2, 10);

    // Reset while waiting for the intersection result
    resp_en = 1'b0;
    req_base = req_count;
    exp_rq1 = vecs[2].rq1;
    exp_rq2 = vecs[2].rq2;
    send(vecs[2].v0, vecs[2].v1, vecs[2].v2);
    cyc = 0;
    while (!isect_start_o && cyc < 50) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    chk1("rstseq_start_seen", isect_start_o, 1'b1);
    @(posedge clk_i); #1;
    chk1("wait_start_low", isect_start_o, 1'b0);
    chk("wait_hold_v1", isect_v1_o, vecs[2].v0);
    chk("wait_hold_v2", isect_v2_o, vecs[2].v1);
    rst_ni = 1'b0;
    #1;
    chk1("midrst_tri_ready", tri_ready_o, 1'b1);
    chk1("midrst_out_valid", out_valid_o, 1'b0);
    chk1("midrst_isect_start", isect_start_o, 1'b0);
    chk1("midrst_cull", cull_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    inject_cnt++;
    begin
      logic bad_v = 1'b0;
      logic bad_c = 1'b0;
      logic bad_r = 1'b0;
      for (int j = 0; j < 6; j++) begin
        @(posedge clk_i); #1;
        if (out_valid_o || out_last_o) bad_v = 1'b1;
        if (cull_o) bad_c = 1'b1;
        if (!tri_ready_o) bad_r = 1'b1;
      end
      chk1("late_done_no_valid", bad_v, 1'b0);
      chk1("late_done_no_cull", bad_c, 1'b0);
      chk1("late_done_stay_idle", bad_r, 1'b0);
    end
    resp_en = 1'b1;
    apply_vec(0, 0);
    apply_vec(2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
